// File: rtl/slc3_mem_arbiter.sv
// rtl/slc3_mem_arbiter.sv - two-requester arbiter for the SLC-3 single-port memory
module slc3_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int READ_LAT   = 2,
    parameter int MAX_CONSEC = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_done,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int SW = (MAX_CONSEC > 0) ? $clog2(MAX_CONSEC + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    logic [CW-1:0] acc_cnt;
    logic [SW-1:0] starv;
    logic        owner_cpu;
    logic        we_l;

    logic              cpu_win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Loader wins unless the CPU has already been passed over MAX_CONSEC times.
    assign cpu_win   = cpu_req && (!ld_req || starv == SW'(MAX_CONSEC));
    assign sel_we    = cpu_win ? cpu_we    : ld_we;
    assign sel_addr  = cpu_win ? cpu_addr  : ld_addr;
    assign sel_wdata = cpu_win ? cpu_wdata : ld_wdata;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            acc_cnt   <= '0;
            starv     <= '0;
            owner_cpu <= 1'b0;
            we_l      <= 1'b0;
            ld_done   <= 1'b0;
            cpu_done  <= 1'b0;
            rdata     <= '0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            ld_done  <= 1'b0;
            cpu_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_req || cpu_req) begin
                        owner_cpu <= cpu_win;
                        we_l      <= sel_we;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_ce    <= 1'b1;
                        busy      <= 1'b1;
                        acc_cnt   <= sel_we ? '0 : CW'(READ_LAT - 1);
                        starv     <= (!cpu_win && cpu_req) ? starv + 1'b1 : '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (acc_cnt == '0) begin
                        if (!we_l) begin
                            rdata <= mem_rdata;
                        end
                        mem_ce   <= 1'b0;
                        mem_we   <= 1'b0;
                        ld_done  <= !owner_cpu;
                        cpu_done <= owner_cpu;
                        state    <= DONE;
                    end else begin
                        acc_cnt <= acc_cnt - 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
